muon_memory_arbiter: RTL and testbench



---
 rtl/muon_mem_pkg.sv | 35 +++
 rtl/muon_hold_timer.sv | 40 ++++
 rtl/muon_memory_arbiter.sv | 152 +++++++++++++++
 tb/tb_muon_memory_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muon_mem_pkg.sv
// Shared types and defaults for the muon buffer memory arbiter.
// Holds the FSM state encoding, requester IDs and the contention winner rule.
package muon_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        TURN  = 2'd3
    } arb_state_e;

    typedef enum logic {
        RQ_A = 1'b0,
        RQ_B = 1'b1
    } rq_id_e;

    localparam int DEF_MAX_HOLD = 256;
    localparam int DEF_HOLD_W   = 9;
    localparam int DEF_TURN_CYC = 1;

    // Under contention the side that did not own the memory last wins.
    function automatic rq_id_e pick_winner(input logic req_a, input logic req_b,
                                           input rq_id_e last_owner);
        rq_id_e w;
        if (req_a && req_b) begin
            w = (last_owner == RQ_A) ? RQ_B : RQ_A;
        end else if (req_b) begin
            w = RQ_B;
        end else begin
            w = RQ_A;
        end
        return w;
    endfunction

endpackage

// File: rtl/muon_hold_timer.sv
// Saturating cycle counter with clear/enable and a terminal flag.
// Times both the ownership hold limit and the turnaround gap.
module muon_hold_timer
    import muon_mem_pkg::*;
#(
    parameter int W = DEF_HOLD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != limit)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == limit);

endmodule

// File: rtl/muon_memory_arbiter.sv
// Arbitrates the muon buffer memory between the trigger writer (A) and DMA readout (B).
// A has priority; B is protected by alternation and a hold limit on either owner.
module muon_memory_arbiter
    import muon_mem_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = DEF_HOLD_W,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ_A,
    input  logic REQ_B,
    input  logic DONE_A,
    input  logic DONE_B,
    input  logic ENA_A_IN,
    input  logic ENA_B_IN,
    output logic GNT_A,
    output logic GNT_B,
    output logic SEL_B,
    output logic ENA_A_OUT,
    output logic ENA_B_OUT,
    output logic PREEMPT,
    output logic ERR
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] TURN_LIM = HOLD_W'(TURN_CYC - 1);

    arb_state_e state_q, state_d;
    rq_id_e     last_q, last_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       sel_b_q, sel_b_d;
    logic       preempt_q, preempt_d;
    logic       err_q, err_d;

    rq_id_e      winner_s;
    logic        other_req_s;
    logic        own_done_s;
    logic        tmr_clr_s;
    logic        tmr_en_s;
    logic        tmr_term_s;
    logic [HOLD_W-1:0] tmr_limit_s;

    muon_hold_timer #(.W(HOLD_W)) u_hold_timer (
        .clk   (CLK),
        .rst   (RST),
        .clr   (tmr_clr_s),
        .en    (tmr_en_s),
        .limit (tmr_limit_s),
        .term  (tmr_term_s)
    );

    // Next-state, ownership bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_b_d     = sel_b_q;
        preempt_d   = 1'b0;
        err_d       = err_q | (DONE_A & ~gnt_a_q) | (DONE_B & ~gnt_b_q);
        winner_s    = pick_winner(REQ_A, REQ_B, last_q);
        other_req_s = 1'b0;
        own_done_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (REQ_A || REQ_B) begin
                    state_d = (winner_s == RQ_B) ? OWN_B : OWN_A;
                    sel_b_d = (winner_s == RQ_B);
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_A, OWN_B: begin
                other_req_s = (state_q == OWN_A) ? REQ_B : REQ_A;
                own_done_s  = (state_q == OWN_A) ? (DONE_A | ~REQ_A) : (DONE_B | ~REQ_B);
                if (own_done_s || (other_req_s && tmr_term_s)) begin
                    state_d   = TURN;
                    last_d    = (state_q == OWN_A) ? RQ_A : RQ_B;
                    preempt_d = ~own_done_s;
                    // Point the mux at the waiting side while the turnaround is dead.
                    if (other_req_s) begin
                        sel_b_d = (state_q == OWN_A);
                    end else begin
                        sel_b_d = sel_b_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            TURN: begin
                if (!tmr_term_s) begin
                    state_d = TURN;
                end else if (REQ_A || REQ_B) begin
                    state_d = (winner_s == RQ_B) ? OWN_B : OWN_A;
                    sel_b_d = (winner_s == RQ_B);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
    end

    // Timer counts contention cycles while owning and dead cycles in TURN.
    always_comb begin
        tmr_en_s    = (state_q == TURN) || other_req_s;
        tmr_limit_s = (state_q == TURN) ? TURN_LIM : HOLD_LIM;
        if ((state_d != state_q) || (state_q == IDLE)) begin
            tmr_clr_s = 1'b1;
        end else if ((state_q == OWN_A) || (state_q == OWN_B)) begin
            tmr_clr_s = ~other_req_s;
        end else begin
            tmr_clr_s = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            last_q    <= RQ_B;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            sel_b_q   <= 1'b0;
            preempt_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            sel_b_q   <= sel_b_d;
            preempt_q <= preempt_d;
            err_q     <= err_d;
        end
    end

    assign GNT_A     = gnt_a_q;
    assign GNT_B     = gnt_b_q;
    assign SEL_B     = sel_b_q;
    assign PREEMPT   = preempt_q;
    assign ERR       = err_q;
    assign ENA_A_OUT = ENA_A_IN & gnt_a_q;
    assign ENA_B_OUT = ENA_B_IN & gnt_b_q;

endmodule

// File: tb/tb_muon_memory_arbiter.sv
// Self-checking bench for muon_memory_arbiter: directed scenarios against a
// cycle-indexed scoreboard, then a randomized protocol-following soak.
module tb_muon_memory_arbiter;

    logic CLK, RST, REQ_A, REQ_B, DONE_A, DONE_B, ENA_A_IN, ENA_B_IN;
    logic GNT_A, GNT_B, SEL_B, ENA_A_OUT, ENA_B_OUT, PREEMPT, ERR;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        int         cyc;
        logic [6:0] v;
    } exp_t;

    exp_t sb_q[$];

    muon_memory_arbiter #(.MAX_HOLD(8), .HOLD_W(9), .TURN_CYC(1)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .DONE_A    (DONE_A),
        .DONE_B    (DONE_B),
        .ENA_A_IN  (ENA_A_IN),
        .ENA_B_IN  (ENA_B_IN),
        .GNT_A     (GNT_A),
        .GNT_B     (GNT_B),
        .SEL_B     (SEL_B),
        .ENA_A_OUT (ENA_A_OUT),
        .ENA_B_OUT (ENA_B_OUT),
        .PREEMPT   (PREEMPT),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Vector order: GNT_A GNT_B SEL_B PREEMPT ERR ENA_A_OUT ENA_B_OUT (ENA inputs held at 1).
    function automatic logic [6:0] mk(input bit ga, input bit gb, input bit sel,
                                      input bit pre, input bit err);
        return {ga, gb, sel, pre, err, ga, gb};
    endfunction

    function automatic bit in_rng(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0; DONE_A = 1'b0; DONE_B = 1'b0;
        ENA_A_IN = 1'b1; ENA_B_IN = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset;
        logic [6:0] obs;
        RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1; DONE_A = 1'b1; DONE_B = 1'b1;
        ENA_A_IN = 1'b1; ENA_B_IN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge CLK);
            obs = {GNT_A, GNT_B, SEL_B, PREEMPT, ERR, ENA_A_OUT, ENA_B_OUT};
            n_chk++;
            if (obs !== 7'b0000000) begin
                n_err++;
                $display("FAIL reset cyc=%0d got=%b want=%b", k, obs, 7'b0000000);
            end
        end
        do_reset();
    endtask

    task automatic test_single_a;
        exp_t e;
        logic [6:0] obs;
        do_reset();
        sb_q.push_back(exp_t'{0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        for (int k = 0; k <= 17; k++) begin
            tick();
            REQ_A = (k <= 10);  DONE_A = (k == 10);
            REQ_B = in_rng(k, 12, 14); DONE_B = (k == 14);
            sb_q.push_back(exp_t'{k + 1, mk(in_rng(k + 1, 1, 10), in_rng(k + 1, 13, 14),
                                            (k + 1 >= 13), 1'b0, 1'b0)});
            @(negedge CLK);
            obs = {GNT_A, GNT_B, SEL_B, PREEMPT, ERR, ENA_A_OUT, ENA_B_OUT};
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_err++;
                $display("FAIL single_a cyc=%0d got=%b want=%b", e.cyc, obs, e.v);
            end
        end
        sb_q.delete();
    endtask

    task automatic test_contention;
        exp_t e;
        logic [6:0] obs;
        do_reset();
        sb_q.push_back(exp_t'{0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        for (int k = 0; k <= 20; k++) begin
            tick();
            REQ_A  = (k <= 4) || in_rng(k, 12, 15);
            DONE_A = (k == 4) || (k == 15);
            REQ_B  = (k <= 9) || in_rng(k, 12, 18);
            DONE_B = (k == 9) || (k == 18);
            sb_q.push_back(exp_t'{k + 1, mk(in_rng(k + 1, 1, 4) || in_rng(k + 1, 13, 15),
                                            in_rng(k + 1, 6, 9) || in_rng(k + 1, 17, 18),
                                            in_rng(k + 1, 5, 12) || (k + 1 >= 16),
                                            1'b0, 1'b0)});
            @(negedge CLK);
            obs = {GNT_A, GNT_B, SEL_B, PREEMPT, ERR, ENA_A_OUT, ENA_B_OUT};
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_err++;
                $display("FAIL contention cyc=%0d got=%b want=%b", e.cyc, obs, e.v);
            end
        end
        sb_q.delete();
    endtask

    task automatic test_preempt;
        exp_t e;
        logic [6:0] obs;
        do_reset();
        sb_q.push_back(exp_t'{0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        for (int k = 0; k <= 24; k++) begin
            tick();
            REQ_A = (k <= 21);          DONE_A = (k == 21);
            REQ_B = in_rng(k, 5, 17);   DONE_B = (k == 17);
            sb_q.push_back(exp_t'{k + 1, mk(in_rng(k + 1, 1, 12) || in_rng(k + 1, 19, 21),
                                            in_rng(k + 1, 14, 17),
                                            in_rng(k + 1, 13, 17),
                                            (k + 1 == 13), 1'b0)});
            @(negedge CLK);
            obs = {GNT_A, GNT_B, SEL_B, PREEMPT, ERR, ENA_A_OUT, ENA_B_OUT};
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_err++;
                $display("FAIL preempt cyc=%0d got=%b want=%b", e.cyc, obs, e.v);
            end
        end
        sb_q.delete();
    endtask

    task automatic test_err_sticky;
        exp_t e;
        logic [6:0] obs;
        do_reset();
        sb_q.push_back(exp_t'{0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        for (int k = 0; k <= 9; k++) begin
            tick();
            REQ_A = 1'b1; DONE_A = 1'b0;
            REQ_B = 1'b0; DONE_B = (k == 3);
            RST   = (k == 7);
            sb_q.push_back(exp_t'{k + 1, mk(in_rng(k + 1, 1, 7) || (k + 1 == 9), 1'b0, 1'b0,
                                            1'b0, in_rng(k + 1, 4, 7))});
            @(negedge CLK);
            obs = {GNT_A, GNT_B, SEL_B, PREEMPT, ERR, ENA_A_OUT, ENA_B_OUT};
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_err++;
                $display("FAIL err_sticky cyc=%0d got=%b want=%b", e.cyc, obs, e.v);
            end
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid_b;
        exp_t e;
        logic [6:0] obs;
        do_reset();
        sb_q.push_back(exp_t'{0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        for (int k = 0; k <= 9; k++) begin
            tick();
            REQ_B = (k <= 3);          DONE_B = 1'b0;
            REQ_A = in_rng(k, 4, 7);   DONE_A = (k == 7);
            RST   = (k == 4);
            sb_q.push_back(exp_t'{k + 1, mk(in_rng(k + 1, 6, 7), in_rng(k + 1, 1, 4),
                                            in_rng(k + 1, 1, 4), 1'b0, 1'b0)});
            @(negedge CLK);
            obs = {GNT_A, GNT_B, SEL_B, PREEMPT, ERR, ENA_A_OUT, ENA_B_OUT};
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e.v) begin
                n_err++;
                $display("FAIL reset_mid_b cyc=%0d got=%b want=%b", e.cyc, obs, e.v);
            end
        end
        sb_q.delete();
    endtask

    task automatic test_random;
        logic prev_ga, prev_gb, prev_sel;
        int   wait_a, wait_b, n_pre, n_gb;
        prev_ga = 1'b0; prev_gb = 1'b0; prev_sel = 1'b0;
        wait_a = 0; wait_b = 0; n_pre = 0; n_gb = 0;
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            tick();
            if (DONE_A) begin
                REQ_A = 1'b0; DONE_A = 1'b0;
            end else if (REQ_A && GNT_A) begin
                DONE_A = ($urandom_range(0, 5) == 0);
            end else if (!REQ_A) begin
                REQ_A = ($urandom_range(0, 3) == 0);
            end
            if (DONE_B) begin
                REQ_B = 1'b0; DONE_B = 1'b0;
            end else if (REQ_B && GNT_B) begin
                DONE_B = ($urandom_range(0, 5) == 0);
            end else if (!REQ_B) begin
                REQ_B = ($urandom_range(0, 3) == 0);
            end
            ENA_A_IN = 1'($urandom_range(0, 1));
            ENA_B_IN = 1'($urandom_range(0, 1));
            @(negedge CLK);
            n_chk++;
            if ((GNT_A & GNT_B) !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_mutex cyc=%0d got=%b%b want=not both", k, GNT_A, GNT_B);
            end
            n_chk++;
            if ((GNT_A && SEL_B !== 1'b0) || (GNT_B && SEL_B !== 1'b1)) begin
                n_err++;
                $display("FAIL rnd_sel_route cyc=%0d got sel=%b ga=%b gb=%b", k, SEL_B, GNT_A, GNT_B);
            end
            if ((prev_ga && GNT_A) || (prev_gb && GNT_B)) begin
                n_chk++;
                if (SEL_B !== prev_sel) begin
                    n_err++;
                    $display("FAIL rnd_sel_stable cyc=%0d got=%b want=%b", k, SEL_B, prev_sel);
                end
            end
            n_chk++;
            if ({ENA_A_OUT, ENA_B_OUT} !== {ENA_A_IN & GNT_A, ENA_B_IN & GNT_B}) begin
                n_err++;
                $display("FAIL rnd_ena cyc=%0d got=%b%b want=%b%b", k, ENA_A_OUT, ENA_B_OUT,
                         ENA_A_IN & GNT_A, ENA_B_IN & GNT_B);
            end
            n_chk++;
            if (ERR !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_err cyc=%0d got=%b want=0", k, ERR);
            end
            wait_a = (REQ_A && !GNT_A) ? wait_a + 1 : 0;
            wait_b = (REQ_B && !GNT_B) ? wait_b + 1 : 0;
            n_chk++;
            if ((wait_a > 24) || (wait_b > 24)) begin
                n_err++;
                $display("FAIL rnd_starve cyc=%0d got wait_a=%0d wait_b=%0d want<=24", k, wait_a, wait_b);
                wait_a = 0; wait_b = 0;
            end
            if (PREEMPT === 1'b1) n_pre++;
            if (GNT_B === 1'b1) n_gb++;
            prev_ga = GNT_A; prev_gb = GNT_B; prev_sel = SEL_B;
        end
        n_chk++;
        if (n_pre == 0) begin
            n_err++;
            $display("FAIL rnd_preempt_seen got=%0d want>0", n_pre);
        end
        n_chk++;
        if (n_gb == 0) begin
            n_err++;
            $display("FAIL rnd_b_served got=%0d want>0", n_gb);
        end
    endtask

    initial begin
        RST = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0; DONE_A = 1'b0; DONE_B = 1'b0;
        ENA_A_IN = 1'b0; ENA_B_IN = 1'b0;
        test_reset();
        test_single_a();
        test_contention();
        test_preempt();
        test_err_sticky();
        test_reset_mid_b();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
